// File: rtl/dmem_pkg.sv
// Shared access-size encodings and default geometry for the data memory stage.
// Combinational/storage only: no latency or backpressure of its own.
package dmem_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam int DMEM_DEPTH = 256;
endpackage

// File: rtl/dmem_store_align.sv
// Store alignment: byte enables plus lane-replicated write data from size/offset.
// Purely combinational, zero latency; no backpressure.
module dmem_store_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [3:0]  byte_en,
  output logic [31:0] lane_wdata
);

  // Data is replicated across lanes so the enable alone picks the target lane.
  always_comb begin
    byte_en    = 4'b0000;
    lane_wdata = wdata;
    case (size)
      SZ_WORD: byte_en = 4'b1111;
      SZ_HALF: begin
        byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{wdata[15:0]}};
      end
      SZ_BYTE: begin
        byte_en    = 4'b0001 << addr_lo;
        lane_wdata = {4{wdata[7:0]}};
      end
      default: byte_en = 4'b0000;
    endcase
  end

endmodule

// File: rtl/data_memory.sv
// Single-cycle MIPS data memory: combinational loads, edge-committed byte/half/word stores.
// Zero-latency reads, stores land at the rising edge; no backpressure, misaligned stores dropped.
module data_memory
  import dmem_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  input  logic        ld_unsigned,
  output logic [31:0] rdata,
  output logic        misaligned,
  output logic        err_sticky
);

  logic [31:0]   mem_q [DEPTH];
  logic          err_sticky_q;
  logic          err_sticky_d;
  logic [AW-1:0] word_idx;
  logic [31:0]   rd_word;
  logic [15:0]   half_sel;
  logic [7:0]    byte_sel;
  logic [3:0]    byte_en;
  logic [31:0]   lane_wdata;
  logic          store_en;
  logic          addr_unused;

  // High address bits are ignored, so addresses alias modulo DEPTH*4.
  assign word_idx    = addr[AW+1:2];
  assign addr_unused = ^addr[31:AW+2];
  assign rd_word     = mem_q[word_idx];

  always_comb begin
    misaligned = 1'b0;
    if (mem_read || mem_write) begin
      misaligned = (size == SZ_RSVD)
                 || ((size == SZ_HALF) && addr[0])
                 || ((size == SZ_WORD) && (addr[1:0] != 2'b00));
    end
  end

  always_comb begin
    half_sel = addr[1] ? rd_word[31:16] : rd_word[15:0];
    case (addr[1:0])
      2'd0:    byte_sel = rd_word[7:0];
      2'd1:    byte_sel = rd_word[15:8];
      2'd2:    byte_sel = rd_word[23:16];
      default: byte_sel = rd_word[31:24];
    endcase
  end

  always_comb begin
    rdata = 32'h0;
    if (mem_read && !misaligned) begin
      case (size)
        SZ_WORD: rdata = rd_word;
        SZ_HALF: rdata = {{16{half_sel[15] & ~ld_unsigned}}, half_sel};
        SZ_BYTE: rdata = {{24{byte_sel[7] & ~ld_unsigned}}, byte_sel};
        default: rdata = 32'h0;
      endcase
    end
  end

  dmem_store_align u_store_align (
    .size       (size),
    .addr_lo    (addr[1:0]),
    .wdata      (wdata),
    .byte_en    (byte_en),
    .lane_wdata (lane_wdata)
  );

  assign store_en     = mem_write && !misaligned;
  assign err_sticky_d = err_sticky_q | misaligned;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'h0;
      end
      err_sticky_q <= 1'b0;
    end else begin
      if (store_en) begin
        for (int k = 0; k < 4; k++) begin
          if (byte_en[k]) begin
            mem_q[word_idx][8*k +: 8] <= lane_wdata[8*k +: 8];
          end
        end
      end
      err_sticky_q <= err_sticky_d;
    end
  end

  assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_data_memory.sv
// Directed plus randomized checks of data_memory against a byte-array reference model.
module tb_data_memory;
  localparam int DEPTH = 256;
  localparam int NBYTES = DEPTH * 4;
  localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, R = 2'b11;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  size;
  logic        ld_unsigned;
  logic [31:0] rdata;
  logic        misaligned;
  logic        err_sticky;

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] obs_rdata;
  logic        obs_mis;
  logic        obs_err;

  // Reference model: flat little-endian byte array plus a sticky error bit.
  logic [7:0] mbytes [NBYTES];
  logic       model_err;
  logic [31:0] exp_rdata;
  logic        exp_mis;

  data_memory #(.DEPTH(DEPTH), .AW(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .addr        (addr),
    .wdata       (wdata),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .size        (size),
    .ld_unsigned (ld_unsigned),
    .rdata       (rdata),
    .misaligned  (misaligned),
    .err_sticky  (err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit model_bad(input logic [31:0] a, input logic [1:0] sz);
    int n;
    if (sz == 2'b11) return 1'b1;
    n = 1 << sz;
    return (a % n) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz,
                                             input logic uns);
    int n;
    int base;
    logic [31:0] v;
    if (model_bad(a, sz)) return 32'h0;
    n = 1 << sz;
    base = int'(a % NBYTES);
    v = 32'h0;
    for (int i = 0; i < n; i++) v = v | (32'(mbytes[(base + i) % NBYTES]) << (8 * i));
    if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  // One cycle: drive at negedge, sample combinational outputs, advance model, sample err after edge.
  task automatic step(input logic r, input logic rd, input logic wr, input logic [1:0] sz,
                      input logic uns, input logic [31:0] a, input logic [31:0] d);
    int n;
    int base;
    @(negedge clk);
    rst = r; mem_read = rd; mem_write = wr; size = sz; ld_unsigned = uns; addr = a; wdata = d;
    #1;
    obs_rdata = rdata;
    obs_mis   = misaligned;
    exp_rdata = rd ? model_load(a, sz, uns) : 32'h0;
    exp_mis   = (rd | wr) & model_bad(a, sz);
    if (r) begin
      for (int i = 0; i < NBYTES; i++) mbytes[i] = 8'h00;
      model_err = 1'b0;
    end else begin
      if (wr && !exp_mis) begin
        n = 1 << sz;
        base = int'(a % NBYTES);
        for (int i = 0; i < n; i++) mbytes[(base + i) % NBYTES] = d[8*i +: 8];
      end
      if (exp_mis) model_err = 1'b1;
    end
    @(posedge clk);
    #1;
    obs_err = err_sticky;
  endtask

  task automatic test_reset;
    step(1, 0, 0, W, 0, 32'h0, 32'h0);
    step(1, 0, 0, W, 0, 32'h0, 32'h0);
    step(0, 0, 0, W, 0, 32'h22, 32'h0);
    n_cmp++; if (obs_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 00000000", obs_rdata); end
    n_cmp++; if (obs_mis !== 1'b0) begin n_fail++; $display("FAIL reset_misaligned: got %b want 0", obs_mis); end
    n_cmp++; if (obs_err !== 1'b0) begin n_fail++; $display("FAIL reset_err_sticky: got %b want 0", obs_err); end
    step(0, 1, 0, W, 0, 32'h10, 32'h0);
    n_cmp++; if (obs_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_mem_clear: got %h want 00000000", obs_rdata); end
  endtask

  task automatic test_word;
    step(0, 0, 1, W, 0, 32'h10, 32'hDEAD_BEEF);
    n_cmp++; if (obs_mis !== 1'b0) begin n_fail++; $display("FAIL sw_misaligned: got %b want 0", obs_mis); end
    step(0, 1, 0, W, 0, 32'h10, 32'h0);
    n_cmp++; if (obs_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lw_0x10: got %h want deadbeef", obs_rdata); end
    n_cmp++; if (obs_mis !== 1'b0) begin n_fail++; $display("FAIL lw_misaligned: got %b want 0", obs_mis); end
    n_cmp++; if (obs_err !== 1'b0) begin n_fail++; $display("FAIL lw_err_sticky: got %b want 0", obs_err); end
  endtask

  task automatic test_byte_lanes;
    logic [31:0] ta [5];
    logic [1:0]  ts [5];
    logic        tu [5];
    logic [31:0] te [5];
    ta = '{32'h13, 32'h13, 32'h10, 32'h12, 32'h10};
    ts = '{B, B, B, H, H};
    tu = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    te = '{32'hFFFF_FFDE, 32'h0000_00DE, 32'hFFFF_FFEF, 32'hFFFF_DEAD, 32'h0000_BEEF};
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, ts[i], tu[i], ta[i], 32'h0);
      n_cmp++;
      if (obs_rdata !== te[i]) begin
        n_fail++;
        $display("FAIL lane_load[%0d] addr=%h size=%0d uns=%b: got %h want %h", i, ta[i], ts[i], tu[i], obs_rdata, te[i]);
      end
    end
  endtask

  task automatic test_partial_stores;
    step(0, 0, 1, B, 0, 32'h11, 32'h0000_00AA);
    step(0, 1, 0, W, 0, 32'h10, 32'h0);
    n_cmp++; if (obs_rdata !== 32'hDEAD_AAEF) begin n_fail++; $display("FAIL sb_0x11: got %h want deadaaef", obs_rdata); end
    step(0, 0, 1, H, 0, 32'h12, 32'h0000_1234);
    step(0, 1, 0, W, 0, 32'h10, 32'h0);
    n_cmp++; if (obs_rdata !== 32'h1234_AAEF) begin n_fail++; $display("FAIL sh_0x12: got %h want 1234aaef", obs_rdata); end
  endtask

  task automatic test_misaligned;
    step(0, 0, 0, W, 0, 32'h23, 32'h0);
    n_cmp++; if (obs_mis !== 1'b0) begin n_fail++; $display("FAIL idle_misaligned: got %b want 0", obs_mis); end
    step(0, 0, 1, W, 0, 32'h22, 32'hFFFF_FFFF);
    n_cmp++; if (obs_mis !== 1'b1) begin n_fail++; $display("FAIL sw_0x22_misaligned: got %b want 1", obs_mis); end
    n_cmp++; if (obs_err !== 1'b1) begin n_fail++; $display("FAIL sw_0x22_err_sticky: got %b want 1", obs_err); end
    step(0, 1, 0, W, 0, 32'h20, 32'h0);
    n_cmp++; if (obs_rdata !== 32'h0) begin n_fail++; $display("FAIL lw_0x20_after_bad_store: got %h want 00000000", obs_rdata); end
    step(0, 1, 0, H, 0, 32'h21, 32'h0);
    n_cmp++; if (obs_rdata !== 32'h0) begin n_fail++; $display("FAIL lh_0x21_rdata: got %h want 00000000", obs_rdata); end
    n_cmp++; if (obs_mis !== 1'b1) begin n_fail++; $display("FAIL lh_0x21_misaligned: got %b want 1", obs_mis); end
    step(0, 1, 0, R, 0, 32'h10, 32'h0);
    n_cmp++; if (obs_mis !== 1'b1 || obs_rdata !== 32'h0) begin n_fail++; $display("FAIL reserved_size: got mis=%b rdata=%h want mis=1 rdata=00000000", obs_mis, obs_rdata); end
    step(0, 1, 0, W, 0, 32'h10, 32'h0);
    n_cmp++; if (obs_err !== 1'b1 || obs_mis !== 1'b0) begin n_fail++; $display("FAIL sticky_holds: got err=%b mis=%b want err=1 mis=0", obs_err, obs_mis); end
  endtask

  task automatic test_back_to_back;
    step(0, 0, 1, W, 0, 32'h40, 32'h1111_1111);
    step(0, 1, 1, W, 0, 32'h40, 32'h2222_2222);
    n_cmp++; if (obs_rdata !== 32'h1111_1111) begin n_fail++; $display("FAIL rdw_old_data: got %h want 11111111", obs_rdata); end
    step(0, 1, 0, W, 0, 32'h40, 32'h0);
    n_cmp++; if (obs_rdata !== 32'h2222_2222) begin n_fail++; $display("FAIL rdw_new_data: got %h want 22222222", obs_rdata); end
    step(0, 0, 1, W, 0, 32'h400, 32'hA5A5_5A5A);
    step(0, 1, 0, W, 0, 32'h0, 32'h0);
    n_cmp++; if (obs_rdata !== 32'hA5A5_5A5A) begin n_fail++; $display("FAIL alias_0x400: got %h want a5a55a5a", obs_rdata); end
  endtask

  task automatic test_reset_priority;
    step(0, 0, 1, W, 0, 32'h8, 32'h77);
    n_cmp++; if (obs_err !== 1'b1) begin n_fail++; $display("FAIL pre_reset_err_sticky: got %b want 1", obs_err); end
    step(1, 0, 1, W, 0, 32'h8, 32'h5);
    n_cmp++; if (obs_err !== 1'b0) begin n_fail++; $display("FAIL rst_clears_err: got %b want 0", obs_err); end
    step(0, 1, 0, W, 0, 32'h8, 32'h0);
    n_cmp++; if (obs_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_drops_store: got %h want 00000000", obs_rdata); end
    step(1, 0, 1, W, 0, 32'h22, 32'h0);
    step(0, 1, 0, W, 0, 32'h40, 32'h0);
    n_cmp++; if (obs_err !== 1'b0 || obs_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_over_fault: got err=%b rdata=%h want err=0 rdata=00000000", obs_err, obs_rdata); end
  endtask

  task automatic test_random;
    logic [31:0] a;
    logic [1:0]  sz;
    logic        rd, wr, uns;
    for (int i = 0; i < 600; i++) begin
      a = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 63)) : 32'($urandom_range(0, NBYTES - 1));
      if ($urandom_range(0, 7) == 0) a = a | ($urandom() & 32'hFFFF_FC00);
      sz  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 5) != 0 && sz == R) sz = W;
      rd  = 1'($urandom_range(0, 1));
      wr  = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      step(0, rd, wr, sz, uns, a, $urandom());
      n_cmp++;
      if (obs_rdata !== exp_rdata || obs_mis !== exp_mis || obs_err !== model_err) begin
        n_fail++;
        $display("FAIL random[%0d] a=%h sz=%0d rd=%b wr=%b: got rdata=%h mis=%b err=%b want rdata=%h mis=%b err=%b",
                 i, a, sz, rd, wr, obs_rdata, obs_mis, obs_err, exp_rdata, exp_mis, model_err);
      end
    end
  endtask

  initial begin
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; size = W; ld_unsigned = 1'b0;
    addr = 32'h0; wdata = 32'h0; model_err = 1'b0;
    for (int i = 0; i < NBYTES; i++) mbytes[i] = 8'h00;
    test_reset;
    test_word;
    test_byte_lanes;
    test_partial_stores;
    test_misaligned;
    test_back_to_back;
    test_reset_priority;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
